// File: rtl/sram_burst_ctrl.sv
// Sequenced burst controller for an asynchronous SRAM with a shared data bus.
// Each beat is SETUP -> ACCESS (WAIT_CYC cycles) -> HOLD; all outputs but cmd_ready are registered.
module sram_burst_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 11,
  parameter int WAIT_CYC = 1,
  parameter int LEN_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                wd_ready_q, wd_ready_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      len_q      <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wd_ready_q <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wd_ready_q <= wd_ready_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    len_d    = len_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // a write waits here until data arrives so the strobe never fires empty
        if (!wr_q) begin
          wait_d  = WAIT_W'(WAIT_CYC - 1);
          state_d = ACCESS;
        end else if (wd_valid && wd_ready_q) begin
          dq_out_d = wdata;
          wait_d   = WAIT_W'(WAIT_CYC - 1);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q == '0) begin
          if (!wr_q) rdata_d = sram_dq_in;
          state_d = HOLD;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      HOLD: begin
        if (len_q == '0) begin
          state_d = IDLE;
        end else begin
          len_d   = len_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered outputs are derived from the upcoming state so they align with it
  always_comb begin
    busy_d     = (state_d != IDLE);
    wd_ready_d = (state_d == SETUP) && wr_d;
    we_n_d     = !((state_d == ACCESS) && wr_d);
    oe_n_d     = !((state_d == ACCESS) && !wr_d);
    dq_oe_d    = wr_d && ((state_d == ACCESS) || (state_d == HOLD));
    rvalid_d   = (state_d == HOLD) && !wr_d;
    done_d     = (state_d == HOLD) && (len_q == '0);
  end

  assign cmd_ready   = (state_q == IDLE);
  assign wd_ready    = wd_ready_q;
  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule
